// File: rtl/rpct_update_ctrl_pkg.sv
// Shared types for the return-PC prediction table (RPCT) update path.
//   rpct_upd_kind_e : kind of a queued training event (call or return)
//   rpct_upd_t      : one queued event {kind, pc_a, pc_b}, 65 bits
//                     call: pc_a = call pc,  pc_b = link pc
//                     ret : pc_a = jr ra pc, pc_b = return target
//   ctrl_state_e    : sequencer state (post-reset clear sweep, then run)
package rpct_update_ctrl_pkg;

    localparam int unsigned PC_W = 32;

    typedef enum logic {
        UPD_CALL = 1'b0,
        UPD_RET  = 1'b1
    } rpct_upd_kind_e;

    typedef struct packed {
        rpct_upd_kind_e  kind;
        logic [PC_W-1:0] pc_a;
        logic [PC_W-1:0] pc_b;
    } rpct_upd_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/rpct_upd_fifo.sv
// Pending-update FIFO for the RPCT sequencer: up to two pushes and one pop
// per cycle, with a flush that drops every queued entry.
//   clk, resetn        : clock, asynchronous active-low reset
//   i_push0 / i_data0  : first write of the cycle (lands at the tail)
//   i_push1 / i_data1  : second write of the cycle (lands after data0);
//                        only ever asserted together with i_push0
//   i_pop              : consume the head entry
//   i_flush            : empty the FIFO; same-cycle pushes and pop ignored
//   o_head             : head entry (meaningless while empty)
//   o_count            : registered occupancy, 0..DEPTH
// The caller guarantees no overflow through its ready logic.
module rpct_upd_fifo
    import rpct_update_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push0,
    input  rpct_upd_t                i_data0,
    input  logic                     i_push1,
    input  rpct_upd_t                i_data1,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output rpct_upd_t                o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    rpct_upd_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_do_pop;
    logic [PTR_W-1:0] w_wr_ptr1;

    assign w_do_pop  = i_pop && !i_flush && (r_count != '0);
    assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!i_flush) begin
            if (i_push0) r_mem[r_wr_ptr]  <= i_data0;
            if (i_push1) r_mem[w_wr_ptr1] <= i_data1;
        end
    end

    // Flush realigns the read pointer onto the write pointer instead of
    // zeroing both, so no storage ever needs to be touched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push0) + PTR_W'(i_push1);
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count  <= r_count + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(w_do_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/rpct_update_ctrl.sv
// Sequencer between EXE and the return-PC prediction table (RPCT).
// Out of reset it sweeps a clear write over every table set, then accepts
// call/return training events into a small FIFO and issues at most one
// table update per cycle. Prediction is gated until the sweep completes.
//   clk, resetn          : clock, asynchronous active-low reset
//   call_valid/pc/link   : resolved call event; call_ready = accepted
//   ret_valid/pc/jrra_pc : resolved jr ra event; ret_ready = accepted
//   flush                : drop all queued, un-issued events
//   tbl_clr_en/idx       : clear write to one table set
//   tbl_is_call/is_ret   : one-cycle update strobes (never both)
//   tbl_call_pc/ret_pc/jrra_pc : update operands; unused ones hold
//   pred_en              : table contents valid
// All outputs except the readies are registered.
module rpct_update_ctrl
    import rpct_update_ctrl_pkg::*;
#(
    parameter int unsigned SET_NUM    = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       call_valid,
    input  logic [31:0]                call_pc,
    input  logic [31:0]                link_pc,
    output logic                       call_ready,
    input  logic                       ret_valid,
    input  logic [31:0]                ret_pc,
    input  logic [31:0]                jrra_pc,
    output logic                       ret_ready,
    input  logic                       flush,
    output logic                       tbl_clr_en,
    output logic [$clog2(SET_NUM)-1:0] tbl_clr_idx,
    output logic                       tbl_is_call,
    output logic                       tbl_is_ret,
    output logic [31:0]                tbl_call_pc,
    output logic [31:0]                tbl_ret_pc,
    output logic [31:0]                tbl_jrra_pc,
    output logic                       pred_en
);

    localparam int unsigned IDX_W = $clog2(SET_NUM);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SET_NUM - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    ctrl_state_e      r_state;
    ctrl_state_e      w_state_nxt;
    logic [IDX_W-1:0] r_clr_cnt;
    logic             r_clr_en;
    logic             r_pred_en;
    logic             r_is_call;
    logic             r_is_ret;
    logic [31:0]      r_call_pc;
    logic [31:0]      r_ret_pc;
    logic [31:0]      r_jrra_pc;

    logic             w_run;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_free;
    logic             w_call_acc;
    logic             w_ret_acc;
    logic             w_push0;
    logic             w_push1;
    rpct_upd_t        w_call_ent;
    rpct_upd_t        w_ret_ent;
    rpct_upd_t        w_data0;
    rpct_upd_t        w_head;
    logic             w_pop;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= INIT;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == INIT && r_clr_cnt == LAST_IDX) w_state_nxt = RUN;
    end

    assign w_run = (r_state == RUN);

    // ---------------- ready / push steering ----------------
    // Readies look only at registered occupancy, so a pop in the same cycle
    // never creates room. A ret needs two free slots when a call also wants
    // in, since the call takes the first slot.
    assign w_free     = DEPTH_C - w_count;
    assign call_ready = w_run && (w_free >= CNT_W'(1));
    assign ret_ready  = w_run && ((w_free >= CNT_W'(2)) ||
                                  ((w_free == CNT_W'(1)) && !call_valid));
    assign w_call_acc = call_valid && call_ready;
    assign w_ret_acc  = ret_valid && ret_ready;

    always_comb begin
        w_call_ent      = '0;
        w_call_ent.kind = UPD_CALL;
        w_call_ent.pc_a = call_pc;
        w_call_ent.pc_b = link_pc;
        w_ret_ent       = '0;
        w_ret_ent.kind  = UPD_RET;
        w_ret_ent.pc_a  = jrra_pc;
        w_ret_ent.pc_b  = ret_pc;
    end

    // A lone ret uses the first write port; with both, call goes first.
    assign w_push0 = w_call_acc || w_ret_acc;
    assign w_push1 = w_call_acc && w_ret_acc;
    assign w_data0 = w_call_acc ? w_call_ent : w_ret_ent;

    assign w_pop = w_run && (w_count != '0) && !flush;

    rpct_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push0 (w_push0),
        .i_data0 (w_data0),
        .i_push1 (w_push1),
        .i_data1 (w_ret_ent),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clr_cnt <= '0;
            r_clr_en  <= 1'b1;
            r_pred_en <= 1'b0;
            r_is_call <= 1'b0;
            r_is_ret  <= 1'b0;
            r_call_pc <= '0;
            r_ret_pc  <= '0;
            r_jrra_pc <= '0;
        end else begin
            if (r_state == INIT) r_clr_cnt <= r_clr_cnt + IDX_W'(1);
            r_clr_en  <= (w_state_nxt == INIT);
            r_pred_en <= (w_state_nxt == RUN);
            r_is_call <= w_pop && (w_head.kind == UPD_CALL);
            r_is_ret  <= w_pop && (w_head.kind == UPD_RET);
            if (w_pop) begin
                if (w_head.kind == UPD_CALL) begin
                    r_call_pc <= w_head.pc_a;
                    r_ret_pc  <= w_head.pc_b;
                end else begin
                    r_jrra_pc <= w_head.pc_a;
                    r_ret_pc  <= w_head.pc_b;
                end
            end
        end
    end

    assign tbl_clr_en  = r_clr_en;
    assign tbl_clr_idx = r_clr_cnt;
    assign tbl_is_call = r_is_call;
    assign tbl_is_ret  = r_is_ret;
    assign tbl_call_pc = r_call_pc;
    assign tbl_ret_pc  = r_ret_pc;
    assign tbl_jrra_pc = r_jrra_pc;
    assign pred_en     = r_pred_en;

endmodule

// File: tb/tb_rpct_update_ctrl.sv
// Self-checking bench for rpct_update_ctrl: directed scenarios followed by
// random traffic, all compared each cycle against a queue-based model.
module tb_rpct_update_ctrl;

    localparam int unsigned SET_NUM    = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        call_valid = 1'b0;
    logic [31:0] call_pc = '0;
    logic [31:0] link_pc = '0;
    logic        call_ready;
    logic        ret_valid = 1'b0;
    logic [31:0] ret_pc = '0;
    logic [31:0] jrra_pc = '0;
    logic        ret_ready;
    logic        flush = 1'b0;
    logic        tbl_clr_en;
    logic [2:0]  tbl_clr_idx;
    logic        tbl_is_call;
    logic        tbl_is_ret;
    logic [31:0] tbl_call_pc;
    logic [31:0] tbl_ret_pc;
    logic [31:0] tbl_jrra_pc;
    logic        pred_en;

    always #5 clk = ~clk;

    rpct_update_ctrl #(
        .SET_NUM    (SET_NUM),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .call_valid  (call_valid),
        .call_pc     (call_pc),
        .link_pc     (link_pc),
        .call_ready  (call_ready),
        .ret_valid   (ret_valid),
        .ret_pc      (ret_pc),
        .jrra_pc     (jrra_pc),
        .ret_ready   (ret_ready),
        .flush       (flush),
        .tbl_clr_en  (tbl_clr_en),
        .tbl_clr_idx (tbl_clr_idx),
        .tbl_is_call (tbl_is_call),
        .tbl_is_ret  (tbl_is_ret),
        .tbl_call_pc (tbl_call_pc),
        .tbl_ret_pc  (tbl_ret_pc),
        .tbl_jrra_pc (tbl_jrra_pc),
        .pred_en     (pred_en)
    );

    // Reference model: pending events in arrival order, cycles since reset,
    // and the expected table-side outputs.
    typedef struct {
        bit          is_ret;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    ev_t         q[$];
    int unsigned m_cyc;
    bit          e_is_call, e_is_ret;
    logic [31:0] e_call_pc, e_ret_pc, e_jrra_pc;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_cyc     = 0;
        e_is_call = 1'b0;
        e_is_ret  = 1'b0;
        e_call_pc = '0;
        e_ret_pc  = '0;
        e_jrra_pc = '0;
    endtask

    task automatic drive(input bit cv, input logic [31:0] cpc, input logic [31:0] lpc,
                         input bit rv, input logic [31:0] jpc, input logic [31:0] rpc,
                         input bit fl);
        call_valid = cv;
        call_pc    = cpc;
        link_pc    = lpc;
        ret_valid  = rv;
        jrra_pc    = jpc;
        ret_pc     = rpc;
        flush      = fl;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
            cycle();
        end
    endtask

    // Reset is asserted away from any clock edge so the checks below see
    // the asynchronous response.
    task automatic do_reset();
        resetn = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        #1;
        check_eq("rst_clr_en",     32'(tbl_clr_en),  32'd1);
        check_eq("rst_clr_idx",    32'(tbl_clr_idx), 32'd0);
        check_eq("rst_pred_en",    32'(pred_en),     32'd0);
        check_eq("rst_is_call",    32'(tbl_is_call), 32'd0);
        check_eq("rst_is_ret",     32'(tbl_is_ret),  32'd0);
        check_eq("rst_call_ready", 32'(call_ready),  32'd0);
        check_eq("rst_ret_ready",  32'(ret_ready),   32'd0);
        check_eq("rst_ret_pc",     tbl_ret_pc,       32'd0);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        ev_t         h;
        bit          run;
        int unsigned fr;
        bit          e_cr, e_rr;
        #1;
        run = (m_cyc >= SET_NUM);
        check_eq("clr_en", 32'(tbl_clr_en), 32'(!run));
        if (!run) check_eq("clr_idx", 32'(tbl_clr_idx), m_cyc);
        check_eq("pred_en",  32'(pred_en),     32'(run));
        check_eq("is_call",  32'(tbl_is_call), 32'(e_is_call));
        check_eq("is_ret",   32'(tbl_is_ret),  32'(e_is_ret));
        check_eq("call_pc",  tbl_call_pc, e_call_pc);
        check_eq("ret_pc",   tbl_ret_pc,  e_ret_pc);
        check_eq("jrra_pc",  tbl_jrra_pc, e_jrra_pc);

        fr   = FIFO_DEPTH - q.size();
        e_cr = run && (fr >= 1);
        e_rr = run && ((fr >= 2) || (fr == 1 && !call_valid));
        check_eq("call_ready", 32'(call_ready), 32'(e_cr));
        check_eq("ret_ready",  32'(ret_ready),  32'(e_rr));

        e_is_call = 1'b0;
        e_is_ret  = 1'b0;
        if (run && q.size() > 0 && !flush) begin
            h = q.pop_front();
            if (h.is_ret) begin
                e_is_ret  = 1'b1;
                e_jrra_pc = h.a;
                e_ret_pc  = h.b;
            end else begin
                e_is_call = 1'b1;
                e_call_pc = h.a;
                e_ret_pc  = h.b;
            end
        end
        if (flush) begin
            q.delete();
        end else begin
            if (call_valid && e_cr) q.push_back('{1'b0, call_pc, link_pc});
            if (ret_valid && e_rr)  q.push_back('{1'b1, jrra_pc, ret_pc});
        end

        @(posedge clk);
        m_cyc++;
        @(negedge clk);
    endtask

    initial begin
        #2;
        do_reset();
        idle(10);

        // single call, expect a one-cycle issue next cycle
        drive(1'b1, 32'hBFC0_0100, 32'hBFC0_0108, 1'b0, '0, '0, 1'b0);
        cycle();
        idle(3);

        // simultaneous call + ret on an empty FIFO
        drive(1'b1, 32'h0000_0100, 32'h0000_0108, 1'b1, 32'h0000_0200, 32'h0000_0108, 1'b0);
        cycle();
        idle(3);

        // sustained double traffic fills the FIFO
        for (int unsigned i = 0; i < 6; i++) begin
            drive(1'b1, 32'h1000 + i * 16, 32'h1004 + i * 16,
                  1'b1, 32'h2000 + i * 16, 32'h3000 + i * 16, 1'b0);
            cycle();
        end
        idle(10);

        // queue three entries, then flush with ret_valid high
        drive(1'b1, 32'h4000, 32'h4004, 1'b1, 32'h5000, 32'h5004, 1'b0);
        cycle();
        drive(1'b1, 32'h4100, 32'h4104, 1'b1, 32'h5100, 32'h5104, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b1, 32'h5200, 32'h5204, 1'b1);
        cycle();
        idle(4);

        // random traffic
        for (int unsigned i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 55, $urandom, $urandom,
                  $urandom_range(0, 99) < 45, $urandom, $urandom,
                  $urandom_range(0, 99) < 4);
            cycle();
        end
        idle(6);

        // reset in the middle of the sweep restarts it from set 0
        do_reset();
        idle(5);
        check_eq("pre_rst_idx", 32'(tbl_clr_idx), 32'd5);
        do_reset();
        idle(12);
        for (int unsigned i = 0; i < 40; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom, $urandom,
                  $urandom_range(0, 1) == 1, $urandom, $urandom, 1'b0);
            cycle();
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
